// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter for valid/ready request streams with burst ownership.
// The grant vector is meant to drive the select input of a downstream AND-OR data mux.
module rr_stream_arbiter #(
    parameter int INPUTS = 4,
    parameter int IW     = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INPUTS-1:0] req_valid,
    input  logic [INPUTS-1:0] req_last,
    output logic [INPUTS-1:0] req_ready,
    output logic [INPUTS-1:0] grant,
    output logic [IW-1:0]     grant_idx,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]    fsm_q, fsm_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] pick;
    logic          any_valid;
    logic          xfer;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (int'(i) >= INPUTS - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Scan from the highest index down so the last hit is the first in rotated order.
    always_comb begin
        logic [IW-1:0] cand;
        pick      = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % INPUTS);
            if (req_valid[cand]) begin
                pick      = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (fsm_q == BUSY) begin
                grant[owner_q] = 1'b1;
            end else if (any_valid) begin
                grant[pick] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IW'(i);
            end
        end
    end

    assign out_valid = |(grant & req_valid);
    assign out_last  = |(grant & req_last);
    assign req_ready = grant & {INPUTS{out_ready}};
    assign xfer      = out_valid & out_ready;

    // A stalled or non-final beat locks the grant until the last beat moves.
    always_comb begin
        fsm_d   = fsm_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (fsm_q == IDLE) begin
            if (xfer && out_last) begin
                ptr_d = wrap_inc(pick);
            end else if (out_valid) begin
                fsm_d   = BUSY;
                owner_d = pick;
            end
        end else if (xfer && out_last) begin
            fsm_d = IDLE;
            ptr_d = wrap_inc(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: directed vector table, then random traffic against
// a rotating-priority reference model.
module tb_rr_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid, req_last, req_ready, grant;
    logic [1:0] grant_idx;
    logic       out_valid, out_last, out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: next highest-priority requester, and burst owner (-1 = none).
    int mptr = 0;
    int mown = -1;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       rs;
        logic [3:0] g;
        logic [3:0] rdy;
        logic       ov;
    } vec_t;

    vec_t tab[$];

    rr_stream_arbiter #(.INPUTS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .grant_idx (grant_idx),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic r, input logic rs,
                       input logic [3:0] g, input logic [3:0] rdy, input logic ov);
        vec_t e;
        e.v = v; e.l = l; e.r = r; e.rs = rs; e.g = g; e.rdy = rdy; e.ov = ov;
        tab.push_back(e);
    endtask

    // One clock: drive at negedge, compare mid-low-phase, then advance the model.
    task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic r, input logic rs,
                         input bit use_tab, input vec_t t);
        logic [3:0] eg;
        int         gi;
        logic       ov, ol;
        @(negedge clk);
        req_valid = v;
        req_last  = l;
        out_ready = r;
        rst       = rs;
        #1;
        eg = 4'b0000;
        gi = 0;
        if (!rs) begin
            if (mown >= 0) begin
                gi = mown;
                eg[gi] = 1'b1;
            end else begin
                for (int k = 3; k >= 0; k--) begin
                    if (v[(mptr + k) % 4]) gi = (mptr + k) % 4;
                end
                if (v != 4'b0000) eg[gi] = 1'b1;
            end
        end
        ov = |(eg & v);
        ol = |(eg & l);
        check("grant", 32'(grant), 32'(eg));
        check("req_ready", 32'(req_ready), 32'(eg & {4{r}}));
        check("out_valid", 32'(out_valid), 32'(ov));
        check("out_last", 32'(out_last), 32'(ol));
        check("grant_idx", 32'(grant_idx), 32'(gi));
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        if (use_tab) begin
            check("tab_grant", 32'(grant), 32'(t.g));
            check("tab_req_ready", 32'(req_ready), 32'(t.rdy));
            check("tab_out_valid", 32'(out_valid), 32'(t.ov));
        end
        if (rs) begin
            mptr = 0;
            mown = -1;
        end else if (ov && r && ol) begin
            mptr = (gi + 1) % 4;
            mown = -1;
        end else if (ov && mown < 0) begin
            mown = gi;
        end
    endtask

    initial begin
        vec_t dummy;
        dummy = '{4'b0, 4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0};
        rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;

        // Reset, then full rotation with single-beat bursts.
        add(4'b1111, 4'b1111, 1, 1, 4'b0000, 4'b0000, 0);
        add(4'b1111, 4'b1111, 1, 0, 4'b0001, 4'b0001, 1);
        add(4'b1111, 4'b1111, 1, 0, 4'b0010, 4'b0010, 1);
        add(4'b1111, 4'b1111, 1, 0, 4'b0100, 4'b0100, 1);
        add(4'b1111, 4'b1111, 1, 0, 4'b1000, 4'b1000, 1);
        add(4'b1111, 4'b1111, 1, 0, 4'b0001, 4'b0001, 1);
        add(4'b1111, 4'b1111, 1, 0, 4'b0010, 4'b0010, 1);
        // Sparse requests starting at ptr=2.
        add(4'b0101, 4'b0101, 1, 0, 4'b0100, 4'b0100, 1);
        add(4'b0101, 4'b0101, 1, 0, 4'b0001, 4'b0001, 1);
        // Requester 1 three-beat burst with requester 0 waiting.
        add(4'b0011, 4'b0000, 1, 0, 4'b0010, 4'b0010, 1);
        add(4'b0011, 4'b0000, 1, 0, 4'b0010, 4'b0010, 1);
        add(4'b0011, 4'b0010, 1, 0, 4'b0010, 4'b0010, 1);
        add(4'b0001, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1);
        // Stall on requester 2; requester 0 arrives mid-stall.
        add(4'b0100, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1);
        add(4'b0101, 4'b0101, 0, 0, 4'b0100, 4'b0000, 1);
        add(4'b0101, 4'b0101, 0, 0, 4'b0100, 4'b0000, 1);
        add(4'b0101, 4'b0101, 0, 0, 4'b0100, 4'b0000, 1);
        add(4'b0101, 4'b0101, 1, 0, 4'b0100, 4'b0100, 1);
        add(4'b0001, 4'b0001, 1, 0, 4'b0001, 4'b0001, 1);
        // Requester 3 burst with a two-cycle bubble.
        add(4'b1000, 4'b0000, 1, 0, 4'b1000, 4'b1000, 1);
        add(4'b0000, 4'b0000, 1, 0, 4'b1000, 4'b1000, 0);
        add(4'b0001, 4'b0001, 1, 0, 4'b1000, 4'b1000, 0);
        add(4'b1000, 4'b0000, 1, 0, 4'b1000, 4'b1000, 1);
        add(4'b1000, 4'b1000, 1, 0, 4'b1000, 4'b1000, 1);
        add(4'b0010, 4'b0010, 1, 0, 4'b0010, 4'b0010, 1);
        // Reset while owner 2 holds a burst.
        add(4'b0100, 4'b0000, 1, 0, 4'b0100, 4'b0100, 1);
        add(4'b0100, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0);
        add(4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 4'b1111, 1, 0, 4'b0001, 4'b0001, 1);

        foreach (tab[i]) begin
            cycle(tab[i].v, tab[i].l, tab[i].r, tab[i].rs, 1'b1, tab[i]);
        end

        for (int n = 0; n < 600; n++) begin
            cycle(4'($urandom), 4'($urandom), ($urandom % 4) != 0, ($urandom % 64) == 0,
                  1'b0, dummy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
